alu_share_arbiter: RTL and testbench
====================================

Name: alu_share_arbiter

Overview:
- Shares one 64-bit execute ALU (add/sub/and/xor, signed overflow flag) between NREQ requesters in the PIPE processor, e.g. the execute stage and the address/aux-compute path.
- Arbitration is round-robin, one grant per cycle.
- Each request uses a valid/ready handshake; the ALU runs combinationally on the granted operands.
- The result, Y86 condition codes and requester ID are registered into a one-entry output buffer with its own valid/ready handshake.

Parameters:
- NREQ, 2, number of requesters; legal values 2..4.
- IDW, 2, width of the requester ID field; must satisfy 2**IDW >= NREQ.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  synchronous, active-low reset.
- req_valid  input  NREQ  per-requester request valid.
- req_ready  output  NREQ  per-requester accept; at most one bit high in any cycle.
- req_op  input  2*NREQ  per-requester op: 0 add, 1 sub, 2 and, 3 xor. Slice i is bits [2i+1:2i].
- req_a  input  64*NREQ  per-requester signed operand A. Slice i is bits [64i+63:64i].
- req_b  input  64*NREQ  per-requester signed operand B. Same slicing as req_a.
- rsp_valid  output  1  output buffer holds a result.
- rsp_ready  input  1  consumer accepts the result.
- rsp_id  output  IDW  index of the requester that owns the result.
- rsp_data  output  64  ALU result.
- rsp_cc  output  3  {ZF, SF, OF}.

Behaviour:
- Reset, sampled on a clk edge with rst_n=0:
  - rsp_valid=0, rsp_id=0, rsp_data=0, rsp_cc=3'b000.
  - Round-robin pointer = 0.
  - A pending result is discarded.
  - req_ready is 0 in every cycle where rst_n=0.
- Buffer state (two states, EMPTY/FULL, tracked by rsp_valid):
  - can_accept = !rsp_valid || rsp_ready.
- Arbitration (combinational, each cycle):
  - Search req_valid starting at pointer, then pointer+1, ... modulo NREQ. The first valid index is the grant g.
  - req_ready[g] = can_accept. All other req_ready bits are 0.
  - If no request is valid, req_ready = 0.
- Transfer: the handshake fires when req_valid[g] && req_ready[g]. On that edge:
  - rsp_data <= A op B, with sub = A - B. Two's complement, wraps modulo 2^64.
  - ZF <= (result == 0).
  - SF <= result[63].
  - OF <= ALU signed overflow for add/sub; 0 for and/xor.
  - rsp_id <= g; rsp_valid <= 1.
  - pointer <= (g+1) mod NREQ.
- Drain with no new grant (rsp_valid && rsp_ready): rsp_valid <= 0. Data, cc and id keep their values.
- Simultaneous drain and grant: the new result replaces the old one and rsp_valid stays 1. This gives full throughput of one op per cycle.
- Stall (rsp_valid && !rsp_ready): no grant, pointer holds, and rsp_data/rsp_cc/rsp_id are stable.
- Latency: request accepted at edge N gives a valid result from edge N to edge N+1, i.e. one cycle.
- Fairness: with all NREQ requesters continuously valid and rsp_ready=1, grants rotate 0,1,..,NREQ-1,0. No requester waits more than NREQ-1 grants.
- Requester rules:
  - Once req_valid[i] is high it stays high, with stable op/a/b, until req_ready[i]. The arbiter does not check this.
  - A requester may drop req_valid only after a transfer.
- The pointer moves only on a transfer. An idle cycle leaves it unchanged.
- Unused grant indices (g >= NREQ) never occur. rsp_id upper bits are 0.

Decomposition:
- Shared package alu_share_pkg holds:
  - op codes ALU_ADD=2'd0, ALU_SUB=2'd1, ALU_AND=2'd2, ALU_XOR=2'd3;
  - CC bit indices CC_ZF=2, CC_SF=1, CC_OF=0.
- Sub-module rr_arbiter (parameter N) contains the pointer register and the rotate/priority-select logic. Its outputs are one-hot grant, grant index and any_valid; its inputs are req and advance.
- The top level instantiates rr_arbiter, the existing 64-bit ALU (operand/op mux driven by the grant index), and the output register.

Test Plan:
- Reset with rsp_valid=1 and stale data -> the cycle after the rst_n=0 edge shows rsp_valid=0, rsp_data=0, rsp_cc=000. Afterwards, req0 with add 5+7 -> rsp_data=12, cc=000, rsp_id=0.
- req1 alone: sub A=3, B=3 -> rsp_data=0, cc=100. Then sub A=0, B=1 -> rsp_data=64'hFFFF_FFFF_FFFF_FFFF, cc=010.
- Overflow cases:
  - add A=64'h7FFF_FFFF_FFFF_FFFF, B=1 -> rsp_data=64'h8000_0000_0000_0000, cc=011.
  - xor A=B=64'hA5 -> rsp_data=0, cc=100 (OF forced 0).
- Fairness: req0 and req1 both always valid, rsp_ready=1 for 6 cycles -> req_ready alternates 01,10,01,10,01,10; rsp_id sequence 0,1,0,1,0,1; one result per cycle.
- Backpressure: rsp_ready=0 for 3 cycles with both requests valid -> req_ready=00, rsp_data/cc/id stable. Then rsp_ready=1 -> drain and the next grant occur on the same edge, and rsp_valid stays 1.
- Reset mid-operation: rst_n=0 for one edge while rsp_valid=1 and the pointer is 1 -> result dropped and pointer=0. With both requesters then valid, the first grant goes to req0.

Source files
------------

// File: rtl/alu_share_pkg.sv
// Shared definitions for the ALU-sharing arbiter: op encodings, condition-code bit
// positions and datapath width.
package alu_share_pkg;

  localparam int DATA_W = 64;

  typedef enum logic [1:0] {
    ALU_ADD = 2'd0,
    ALU_SUB = 2'd1,
    ALU_AND = 2'd2,
    ALU_XOR = 2'd3
  } alu_op_e;

  localparam int CC_ZF = 2;
  localparam int CC_SF = 1;
  localparam int CC_OF = 0;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: priority search starts at the pointer, which moves past the
// winner only when the grant is actually consumed (advance).
module rr_arbiter #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  req,
  input  logic          advance,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx,
  output logic          any_valid
);

  logic [IW-1:0] ptr;

  always_comb begin
    int idx;
    idx       = 0;
    grant     = '0;
    grant_idx = '0;
    any_valid = 1'b0;
    for (int k = 0; k < N; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N) idx -= N;
      if (!any_valid && req[idx]) begin
        any_valid  = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = IW'(idx);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (advance) begin
      if (int'(grant_idx) == N - 1) ptr <= '0;
      else                          ptr <= grant_idx + 1'b1;
    end
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// One shared 64-bit ALU serving NREQ requesters through a round-robin arbiter, with a
// one-entry registered result buffer (data, {ZF,SF,OF}, owner id).
module alu_share_arbiter
  import alu_share_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int IDW  = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [2*NREQ-1:0]      req_op,
  input  logic [64*NREQ-1:0]     req_a,
  input  logic [64*NREQ-1:0]     req_b,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [IDW-1:0]         rsp_id,
  output logic [63:0]            rsp_data,
  output logic [2:0]             rsp_cc
);

  logic [NREQ-1:0]          grant;
  logic [IDW-1:0]           grant_idx;
  logic                     any_valid;
  logic                     can_accept;
  logic                     fire;
  alu_op_e                  op_sel;
  logic signed [DATA_W-1:0] a_sel;
  logic signed [DATA_W-1:0] b_sel;
  logic [DATA_W:0]          alu_out;
  logic signed [DATA_W-1:0] res;
  logic [2:0]               cc_next;

  logic                     vld_p0;
  logic signed [DATA_W-1:0] data_p0;
  logic [2:0]               cc_p0;
  logic [IDW-1:0]           id_p0;

  // Returns {overflow, result}; overflow only meaningful for add/sub.
  function automatic logic [DATA_W:0] alu_eval(input alu_op_e op,
                                                input logic signed [DATA_W-1:0] a,
                                                input logic signed [DATA_W-1:0] b);
    logic signed [DATA_W-1:0] r;
    logic                     of;
    r  = '0;
    of = 1'b0;
    case (op)
      ALU_ADD: begin
        r  = a + b;
        of = (a[DATA_W-1] == b[DATA_W-1]) && (r[DATA_W-1] != a[DATA_W-1]);
      end
      ALU_SUB: begin
        r  = a - b;
        of = (a[DATA_W-1] != b[DATA_W-1]) && (r[DATA_W-1] != a[DATA_W-1]);
      end
      ALU_AND: r = a & b;
      default: r = a ^ b;
    endcase
    return {of, r};
  endfunction

  assign can_accept = !vld_p0 || rsp_ready;
  assign fire       = rst_n && can_accept && any_valid;
  assign req_ready  = (rst_n && can_accept) ? grant : '0;

  rr_arbiter #(
    .N  (NREQ),
    .IW (IDW)
  ) u_rr_arbiter (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req_valid),
    .advance   (fire),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any_valid (any_valid)
  );

  always_comb begin
    op_sel = ALU_ADD;
    a_sel  = '0;
    b_sel  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_idx == IDW'(i)) begin
        op_sel = alu_op_e'(req_op[2*i +: 2]);
        a_sel  = req_a[64*i +: 64];
        b_sel  = req_b[64*i +: 64];
      end
    end
  end

  assign alu_out = alu_eval(op_sel, a_sel, b_sel);
  assign res     = alu_out[DATA_W-1:0];

  always_comb begin
    cc_next        = '0;
    cc_next[CC_ZF] = (res == '0);
    cc_next[CC_SF] = res[DATA_W-1];
    cc_next[CC_OF] = alu_out[DATA_W];
  end

  // Stage p0: result buffer; a grant on the same edge as a drain overwrites in place.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p0  <= 1'b0;
      data_p0 <= '0;
      cc_p0   <= '0;
      id_p0   <= '0;
    end else if (fire) begin
      vld_p0  <= 1'b1;
      data_p0 <= res;
      cc_p0   <= cc_next;
      id_p0   <= grant_idx;
    end else if (rsp_ready) begin
      vld_p0  <= 1'b0;
    end
  end

  assign rsp_valid = vld_p0;
  assign rsp_data  = data_p0;
  assign rsp_cc    = cc_p0;
  assign rsp_id    = id_p0;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with two requesters and hand-computed results.
module tb_alu_share_arbiter;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [1:0]   req_valid;
  logic [1:0]   req_ready;
  logic [3:0]   req_op;
  logic [127:0] req_a;
  logic [127:0] req_b;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [1:0]   rsp_id;
  logic [63:0]  rsp_data;
  logic [2:0]   rsp_cc;

  int checks   = 0;
  int failures = 0;

  alu_share_arbiter #(.NREQ(2), .IDW(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .rsp_cc    (rsp_cc)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int i, input logic v, input logic [1:0] op,
                       input logic [63:0] a, input logic [63:0] b);
    req_valid[i]     = v;
    req_op[2*i +: 2] = op;
    req_a[64*i +: 64] = a;
    req_b[64*i +: 64] = b;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = '0; req_op = '0; req_a = '0; req_b = '0; rsp_ready = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    drive(0, 1'b1, 2'd0, 64'd1, 64'd2);
    tick();
    req_valid = '0;
    checks++; if (rsp_valid !== 1'b1 || rsp_data !== 64'd3)
      begin failures++; $display("FAIL stale_setup valid=%b data=%h exp 1/3", rsp_valid, rsp_data); end
    rst_n = 1'b0; rsp_ready = 1'b1;
    drive(0, 1'b1, 2'd0, 64'd5, 64'd7);
    #1;
    checks++; if (req_ready !== 2'b00)
      begin failures++; $display("FAIL ready_in_reset got=%b exp=00", req_ready); end
    tick();
    checks++; if ({rsp_valid, rsp_id, rsp_data, rsp_cc} !== {1'b0, 2'd0, 64'd0, 3'b000})
      begin failures++; $display("FAIL reset_state v=%b id=%0d d=%h cc=%b exp 0/0/0/000", rsp_valid, rsp_id, rsp_data, rsp_cc); end
    rst_n = 1'b1;
    #1;
    checks++; if (req_ready !== 2'b01)
      begin failures++; $display("FAIL post_reset_ready got=%b exp=01", req_ready); end
    tick();
    req_valid = '0;
    checks++; if ({rsp_valid, rsp_id, rsp_data, rsp_cc} !== {1'b1, 2'd0, 64'd12, 3'b000})
      begin failures++; $display("FAIL add_5_7 v=%b id=%0d d=%h cc=%b exp 1/0/c/000", rsp_valid, rsp_id, rsp_data, rsp_cc); end
  endtask

  task automatic test_overflow();
    logic [1:0]  ops  [4] = '{2'd0, 2'd1, 2'd2, 2'd3};
    logic [63:0] as   [4] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 64'hFF00, 64'hA5};
    logic [63:0] bs   [4] = '{64'd1, 64'd1, 64'h0F0F, 64'hA5};
    logic [63:0] exd  [4] = '{64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF, 64'h0F00, 64'd0};
    logic [2:0]  excc [4] = '{3'b011, 3'b001, 3'b000, 3'b100};
    rsp_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      drive(0, 1'b1, ops[k], as[k], bs[k]);
      tick();
      checks++; if ({rsp_valid, rsp_id, rsp_data, rsp_cc} !== {1'b1, 2'd0, exd[k], excc[k]})
        begin failures++; $display("FAIL ovf_case%0d v=%b id=%0d d=%h cc=%b exp d=%h cc=%b", k, rsp_valid, rsp_id, rsp_data, rsp_cc, exd[k], excc[k]); end
    end
    req_valid = '0;
  endtask

  task automatic test_sub();
    rsp_ready = 1'b1;
    drive(1, 1'b1, 2'd1, 64'd3, 64'd3);
    #1;
    checks++; if (req_ready !== 2'b10)
      begin failures++; $display("FAIL sub_ready got=%b exp=10", req_ready); end
    tick();
    checks++; if ({rsp_valid, rsp_id, rsp_data, rsp_cc} !== {1'b1, 2'd1, 64'd0, 3'b100})
      begin failures++; $display("FAIL sub_3_3 v=%b id=%0d d=%h cc=%b exp 1/1/0/100", rsp_valid, rsp_id, rsp_data, rsp_cc); end
    drive(1, 1'b1, 2'd1, 64'd0, 64'd1);
    tick();
    req_valid = '0;
    checks++; if ({rsp_valid, rsp_id, rsp_data, rsp_cc} !== {1'b1, 2'd1, 64'hFFFF_FFFF_FFFF_FFFF, 3'b010})
      begin failures++; $display("FAIL sub_0_1 v=%b id=%0d d=%h cc=%b exp 1/1/ffff_ffff_ffff_ffff/010", rsp_valid, rsp_id, rsp_data, rsp_cc); end
  endtask

  task automatic test_drain();
    rsp_ready = 1'b1;
    tick();
    checks++; if ({rsp_valid, rsp_id, rsp_data, rsp_cc} !== {1'b0, 2'd1, 64'hFFFF_FFFF_FFFF_FFFF, 3'b010})
      begin failures++; $display("FAIL drain v=%b id=%0d d=%h cc=%b exp 0 with data held", rsp_valid, rsp_id, rsp_data, rsp_cc); end
  endtask

  task automatic test_fairness();
    rsp_ready = 1'b1;
    drive(0, 1'b1, 2'd0, 64'd10, 64'd1);
    drive(1, 1'b1, 2'd1, 64'd10, 64'd1);
    for (int k = 0; k < 6; k++) begin
      #1;
      checks++; if (req_ready !== ((k % 2 == 0) ? 2'b01 : 2'b10))
        begin failures++; $display("FAIL fair_ready%0d got=%b", k, req_ready); end
      tick();
      checks++; if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, 2'(k % 2), ((k % 2 == 0) ? 64'd11 : 64'd9)})
        begin failures++; $display("FAIL fair_rsp%0d v=%b id=%0d d=%h", k, rsp_valid, rsp_id, rsp_data); end
    end
  endtask

  task automatic test_backpressure();
    rsp_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++; if (req_ready !== 2'b00)
        begin failures++; $display("FAIL bp_ready%0d got=%b exp=00", k, req_ready); end
      tick();
      checks++; if ({rsp_valid, rsp_id, rsp_data, rsp_cc} !== {1'b1, 2'd1, 64'd9, 3'b000})
        begin failures++; $display("FAIL bp_hold%0d v=%b id=%0d d=%h cc=%b exp 1/1/9/000", k, rsp_valid, rsp_id, rsp_data, rsp_cc); end
    end
    rsp_ready = 1'b1;
    #1;
    checks++; if (req_ready !== 2'b01)
      begin failures++; $display("FAIL bp_release_ready got=%b exp=01", req_ready); end
    tick();
    req_valid = '0;
    checks++; if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, 2'd0, 64'd11})
      begin failures++; $display("FAIL bp_drain_grant v=%b id=%0d d=%h exp 1/0/b", rsp_valid, rsp_id, rsp_data); end
    tick();
  endtask

  task automatic test_reset_mid();
    rsp_ready = 1'b0;
    drive(0, 1'b1, 2'd0, 64'd2, 64'd2);
    tick();
    req_valid = '0;
    checks++; if ({rsp_valid, rsp_data} !== {1'b1, 64'd4})
      begin failures++; $display("FAIL mid_setup v=%b d=%h exp 1/4", rsp_valid, rsp_data); end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checks++; if ({rsp_valid, rsp_data, rsp_cc} !== {1'b0, 64'd0, 3'b000})
      begin failures++; $display("FAIL mid_reset v=%b d=%h cc=%b exp 0/0/000", rsp_valid, rsp_data, rsp_cc); end
    rsp_ready = 1'b1;
    drive(0, 1'b1, 2'd3, 64'hF0, 64'h0F);
    drive(1, 1'b1, 2'd0, 64'd1, 64'd1);
    #1;
    checks++; if (req_ready !== 2'b01)
      begin failures++; $display("FAIL mid_first_ready got=%b exp=01", req_ready); end
    tick();
    req_valid = '0;
    checks++; if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, 2'd0, 64'hFF})
      begin failures++; $display("FAIL mid_first_grant v=%b id=%0d d=%h exp 1/0/ff", rsp_valid, rsp_id, rsp_data); end
  endtask

  initial begin
    test_reset();
    test_overflow();
    test_sub();
    test_drain();
    test_fairness();
    test_backpressure();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
